// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared AXI4-Lite channel types and widths for the register-bank bus.
// Items:
//   ADDR_WIDTH / DATA_WIDTH / STRB_WIDTH   channel widths
//   addr_t, data_t, strb_t                 payload types
//   resp_t                                 2-bit response code (RESP_*)
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;

    // Encoding follows the AXI response field directly
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

endpackage : axi_lite_pkg

// File: rtl/axi_lite_chan_hold.sv
// ---------------------------------------------------------------------------
// axi_lite_chan_hold
// One-entry valid/ready hold register for an AXI4-Lite request channel.
// The entry loads on a handshake and is cleared when the consumer takes it.
// Ready is purely a function of the hold state, never of in_valid.
// Ports:
//   clk       in   1       clock, rising edge
//   rstn      in   1       synchronous active-low reset, empties the hold
//   in_data   in   WIDTH   channel payload
//   in_valid  in   1       channel valid
//   in_ready  out  1       channel ready (hold is empty)
//   consume   in   1       consumer takes the held entry this cycle
//   held      out  1       hold contains an entry
//   out_data  out  WIDTH   held payload
// ---------------------------------------------------------------------------
module axi_lite_chan_hold
    import axi_lite_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             consume,
    output logic             held,
    output logic [WIDTH-1:0] out_data
);

    logic             held_q;
    logic [WIDTH-1:0] data_q;

    // Load and consume can never coincide: loading requires an empty hold
    // while consuming requires a full one, so a simple priority is safe.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            held_q <= 1'b0;
            data_q <= '0;
        end else if (in_valid && !held_q) begin
            held_q <= 1'b1;
            data_q <= in_data;
        end else if (consume) begin
            held_q <= 1'b0;
        end
    end

    assign in_ready = !held_q;
    assign held     = held_q;
    assign out_data = data_q;

endmodule : axi_lite_chan_hold

// File: rtl/axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_regs
// AXI4-Lite responder fronting a bank of NUM_REGS 32-bit read/write registers.
// Registers are word-addressed from BASE_ADDR; out-of-range accesses answer
// DECERR, leave the bank untouched and read back zero. Contents are exported
// flat on regs_o for control logic.
// Parameters:
//   NUM_REGS   number of registers (power of two)
//   BASE_ADDR  byte address of register 0, aligned to 4*NUM_REGS
// Ports:
//   clk, rstn                        clock / synchronous active-low reset
//   awaddr, awvalid, awready         write address channel
//   wdata, wstrb, wvalid, wready     write data channel
//   bresp, bvalid, bready            write response channel
//   araddr, arvalid, arready         read address channel
//   rdata, rresp, rvalid, rready     read data channel
//   regs_o                           register i at [32*i +: 32]
// ---------------------------------------------------------------------------
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int    NUM_REGS  = 8,
    parameter addr_t BASE_ADDR = 32'h0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [ADDR_WIDTH-1:0]    awaddr,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [STRB_WIDTH-1:0]    wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [ADDR_WIDTH-1:0]    araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [NUM_REGS*32-1:0]   regs_o
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int WHOLD_W = DATA_WIDTH + STRB_WIDTH;

    // An address below BASE_ADDR wraps to a huge word offset, so a single
    // upper-bound compare covers both ends of the window.
    function automatic logic addr_in_range(input addr_t a);
        return ((a - BASE_ADDR) >> 2) < addr_t'(NUM_REGS);
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input addr_t a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    // ------------------------------------------------------------------
    // Request holds for AW and W
    // ------------------------------------------------------------------
    logic               aw_held;
    addr_t              aw_addr_q;
    logic               w_held;
    logic [WHOLD_W-1:0] w_hold_q;
    data_t              w_data_q;
    strb_t              w_strb_q;
    logic               commit;

    axi_lite_chan_hold #(
        .WIDTH (ADDR_WIDTH)
    ) u_aw_hold (
        .clk      (clk),
        .rstn     (rstn),
        .in_data  (awaddr),
        .in_valid (awvalid),
        .in_ready (awready),
        .consume  (commit),
        .held     (aw_held),
        .out_data (aw_addr_q)
    );

    axi_lite_chan_hold #(
        .WIDTH (WHOLD_W)
    ) u_w_hold (
        .clk      (clk),
        .rstn     (rstn),
        .in_data  ({wdata, wstrb}),
        .in_valid (wvalid),
        .in_ready (wready),
        .consume  (commit),
        .held     (w_held),
        .out_data (w_hold_q)
    );

    assign {w_data_q, w_strb_q} = w_hold_q;

    // ------------------------------------------------------------------
    // Write commit
    // ------------------------------------------------------------------
    logic             bvalid_q;
    resp_t            bresp_q;
    logic             wr_hit;
    logic [IDX_W-1:0] wr_idx;

    // A commit needs both halves of the request and a free B slot; a B being
    // accepted this same cycle counts as free so writes can stream.
    assign commit = aw_held && w_held && (!bvalid_q || bready);
    assign wr_hit = addr_in_range(aw_addr_q);
    assign wr_idx = addr_index(aw_addr_q);

    data_t regs_q [NUM_REGS];

    // Register bank: byte-lane writes on commit, only when the address hits
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit && wr_hit) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (w_strb_q[b]) begin
                    regs_q[wr_idx][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

    // B channel: a commit loads a fresh response even if the previous one is
    // being accepted in the same cycle; otherwise bready retires it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_hit ? RESP_OKAY : RESP_DECERR;
        end else if (bready) begin
            bvalid_q <= 1'b0;
        end
    end

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    logic             rvalid_q;
    data_t            rdata_q;
    resp_t            rresp_q;
    logic             ar_fire;
    logic             rd_hit;
    logic [IDX_W-1:0] rd_idx;

    assign arready = !rvalid_q || rready;
    assign ar_fire = arvalid && arready;
    assign rd_hit  = addr_in_range(araddr);
    assign rd_idx  = addr_index(araddr);

    // The bank is sampled before any same-cycle commit lands, so a read that
    // races a write to the same register returns the old contents.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_hit ? regs_q[rd_idx] : '0;
            rresp_q  <= rd_hit ? RESP_OKAY : RESP_DECERR;
        end else if (rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;

    // ------------------------------------------------------------------
    // Flat export of the bank
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_o[32*g +: 32] = regs_q[g];
    end

endmodule : axi_lite_slave_regs

// File: tb/tb_axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_slave_regs
// Directed bench for the AXI4-Lite register bank (NUM_REGS=8, BASE_ADDR=0).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so every value observed reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_axi_lite_slave_regs;

    logic         clk = 1'b0;
    logic         rstn;
    logic [31:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [31:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [255:0] regs_o;

    int assert_count = 0;
    int fail_count   = 0;

    axi_lite_slave_regs #(
        .NUM_REGS  (8),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .regs_o  (regs_o)
    );

    always #5 clk = ~clk;

    // Advance one clock and land just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        assert_count++; if (awready !== 1'b1) begin fail_count++; $display("[TB] FAIL reset_awready: got %b expected 1", awready); end
        assert_count++; if (wready !== 1'b1) begin fail_count++; $display("[TB] FAIL reset_wready: got %b expected 1", wready); end
        assert_count++; if (arready !== 1'b1) begin fail_count++; $display("[TB] FAIL reset_arready: got %b expected 1", arready); end
        assert_count++; if (bvalid !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_bvalid: got %b expected 0", bvalid); end
        assert_count++; if (rvalid !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_rvalid: got %b expected 0", rvalid); end
        assert_count++; if (regs_o !== 256'h0) begin fail_count++; $display("[TB] FAIL reset_regs: got %h expected 0", regs_o); end
        assert_count++; if (bresp !== 2'b00 || rresp !== 2'b00) begin fail_count++; $display("[TB] FAIL reset_resp: got b=%b r=%b expected 00/00", bresp, rresp); end
        assert_count++; if (rdata !== 32'h0) begin fail_count++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    endtask

    // AW and W together; B two cycles after the handshake; read back
    task automatic test_same_cycle_write();
        bready = 1'b1;
        awaddr = 32'h4; awvalid = 1'b1;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        assert_count++; if (bvalid !== 1'b0) begin fail_count++; $display("[TB] FAIL sc_b_early: got %b expected 0", bvalid); end
        assert_count++; if (awready !== 1'b0 || wready !== 1'b0) begin fail_count++; $display("[TB] FAIL sc_holds_full: got aw=%b w=%b expected 0/0", awready, wready); end
        tick();
        assert_count++; if (bvalid !== 1'b1) begin fail_count++; $display("[TB] FAIL sc_bvalid: got %b expected 1", bvalid); end
        assert_count++; if (bresp !== 2'b00) begin fail_count++; $display("[TB] FAIL sc_bresp: got %b expected 00", bresp); end
        assert_count++; if (regs_o[63:32] !== 32'hDEADBEEF) begin fail_count++; $display("[TB] FAIL sc_reg1: got %h expected DEADBEEF", regs_o[63:32]); end
        tick();
        assert_count++; if (bvalid !== 1'b0) begin fail_count++; $display("[TB] FAIL sc_b_retire: got %b expected 0", bvalid); end
        rready = 1'b0;
        araddr = 32'h4; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        assert_count++; if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rresp !== 2'b00) begin fail_count++; $display("[TB] FAIL sc_read: got v=%b d=%h r=%b expected 1/DEADBEEF/00", rvalid, rdata, rresp); end
        assert_count++; if (arready !== 1'b0) begin fail_count++; $display("[TB] FAIL sc_arready_stall: got %b expected 0", arready); end
        rready = 1'b1;
        tick();
        assert_count++; if (rvalid !== 1'b0) begin fail_count++; $display("[TB] FAIL sc_r_retire: got %b expected 0", rvalid); end
        rready = 1'b0;
    endtask

    // W first with partial strobes, AW three cycles later
    task automatic test_w_first();
        bready = 1'b1;
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        assert_count++; if (wready !== 1'b0 || awready !== 1'b1) begin fail_count++; $display("[TB] FAIL wf_ready: got aw=%b w=%b expected 1/0", awready, wready); end
        tick();
        tick();
        assert_count++; if (bvalid !== 1'b0) begin fail_count++; $display("[TB] FAIL wf_no_early_b: got %b expected 0", bvalid); end
        awaddr = 32'h8; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        assert_count++; if (bvalid !== 1'b0) begin fail_count++; $display("[TB] FAIL wf_b_latency: got %b expected 0", bvalid); end
        tick();
        assert_count++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin fail_count++; $display("[TB] FAIL wf_b: got v=%b r=%b expected 1/00", bvalid, bresp); end
        assert_count++; if (regs_o[95:64] !== 32'h00220044) begin fail_count++; $display("[TB] FAIL wf_reg2: got %h expected 00220044", regs_o[95:64]); end
        tick();
        assert_count++; if (bvalid !== 1'b0) begin fail_count++; $display("[TB] FAIL wf_single_b1: got %b expected 0", bvalid); end
        tick();
        assert_count++; if (bvalid !== 1'b0) begin fail_count++; $display("[TB] FAIL wf_single_b2: got %b expected 0", bvalid); end
    endtask

    // Out-of-range write and read answer DECERR and touch nothing
    task automatic test_decerr();
        logic [255:0] exp_all;
        exp_all = '0;
        exp_all[63:32] = 32'hDEADBEEF;
        exp_all[95:64] = 32'h00220044;
        bready = 1'b1;
        awaddr = 32'h40; awvalid = 1'b1;
        wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        assert_count++; if (bvalid !== 1'b1 || bresp !== 2'b11) begin fail_count++; $display("[TB] FAIL de_bresp: got v=%b r=%b expected 1/11", bvalid, bresp); end
        assert_count++; if (regs_o !== exp_all) begin fail_count++; $display("[TB] FAIL de_regs: got %h expected %h", regs_o, exp_all); end
        tick();
        rready = 1'b0;
        araddr = 32'h40; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        assert_count++; if (rvalid !== 1'b1 || rresp !== 2'b11 || rdata !== 32'h0) begin fail_count++; $display("[TB] FAIL de_read: got v=%b r=%b d=%h expected 1/11/0", rvalid, rresp, rdata); end
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    // B stalls five cycles while a second request fills the holds
    task automatic test_b_stall();
        bready = 1'b0;
        awaddr = 32'hC; awvalid = 1'b1;
        wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awaddr = 32'h10; wdata = 32'h77;
        tick();
        assert_count++; if (bvalid !== 1'b1 || awready !== 1'b1) begin fail_count++; $display("[TB] FAIL bs_first: got bv=%b awr=%b expected 1/1", bvalid, awready); end
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        assert_count++; if (regs_o[127:96] !== 32'h5) begin fail_count++; $display("[TB] FAIL bs_reg3: got %h expected 5", regs_o[127:96]); end
        for (int i = 0; i < 5; i++) begin
            assert_count++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin fail_count++; $display("[TB] FAIL bs_b1_hold[%0d]: got v=%b r=%b expected 1/00", i, bvalid, bresp); end
            assert_count++; if (awready !== 1'b0 || wready !== 1'b0) begin fail_count++; $display("[TB] FAIL bs_ready_low[%0d]: got aw=%b w=%b expected 0/0", i, awready, wready); end
            assert_count++; if (regs_o[159:128] !== 32'h0) begin fail_count++; $display("[TB] FAIL bs_reg4_pending[%0d]: got %h expected 0", i, regs_o[159:128]); end
            tick();
        end
        bready = 1'b1;
        tick();
        assert_count++; if (bvalid !== 1'b1 || regs_o[159:128] !== 32'h77) begin fail_count++; $display("[TB] FAIL bs_b2: got bv=%b reg4=%h expected 1/77", bvalid, regs_o[159:128]); end
        tick();
        assert_count++; if (bvalid !== 1'b0) begin fail_count++; $display("[TB] FAIL bs_b2_retire: got %b expected 0", bvalid); end
    endtask

    // Read racing a commit to the same register sees the old value
    task automatic test_read_old_value();
        bready = 1'b1; rready = 1'b0;
        awaddr = 32'hC; awvalid = 1'b1;
        wdata = 32'h9; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'hC; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        assert_count++; if (rvalid !== 1'b1 || rdata !== 32'h5) begin fail_count++; $display("[TB] FAIL ro_old: got v=%b d=%h expected 1/5", rvalid, rdata); end
        assert_count++; if (regs_o[127:96] !== 32'h9 || bvalid !== 1'b1) begin fail_count++; $display("[TB] FAIL ro_commit: got reg3=%h bv=%b expected 9/1", regs_o[127:96], bvalid); end
        rready = 1'b1;
        tick();
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        assert_count++; if (rvalid !== 1'b1 || rdata !== 32'h9) begin fail_count++; $display("[TB] FAIL ro_new: got v=%b d=%h expected 1/9", rvalid, rdata); end
        tick();
        rready = 1'b0;
    endtask

    // Reads at one per cycle, then an R stall holding the payload
    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        logic [31:0] exps  [4];
        addrs = '{32'h4, 32'h8, 32'hC, 32'h10};
        exps  = '{32'hDEADBEEF, 32'h00220044, 32'h9, 32'h77};
        rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            araddr = addrs[i]; arvalid = 1'b1;
            assert_count++; if (arready !== 1'b1) begin fail_count++; $display("[TB] FAIL bb_arready[%0d]: got %b expected 1", i, arready); end
            tick();
            assert_count++; if (rvalid !== 1'b1 || rdata !== exps[i]) begin fail_count++; $display("[TB] FAIL bb_read[%0d]: got v=%b d=%h expected 1/%h", i, rvalid, rdata, exps[i]); end
        end
        arvalid = 1'b0;
        tick();
        assert_count++; if (rvalid !== 1'b0) begin fail_count++; $display("[TB] FAIL bb_drain: got %b expected 0", rvalid); end
        rready = 1'b0;
        araddr = 32'h4; arvalid = 1'b1;
        tick();
        araddr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            assert_count++; if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || arready !== 1'b0) begin fail_count++; $display("[TB] FAIL bb_r_stall[%0d]: got v=%b d=%h ar=%b expected 1/DEADBEEF/0", i, rvalid, rdata, arready); end
            tick();
        end
        arvalid = 1'b0;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    // Reset with a W held and an R pending drops both without a response
    task automatic test_reset_mid();
        bready = 1'b1; rready = 1'b0;
        wdata = 32'hAA; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 32'h4; arvalid = 1'b1;
        tick();
        wvalid = 1'b0; arvalid = 1'b0;
        assert_count++; if (wready !== 1'b0 || rvalid !== 1'b1) begin fail_count++; $display("[TB] FAIL rm_pre: got w=%b rv=%b expected 0/1", wready, rvalid); end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        assert_count++; if (wready !== 1'b1 || rvalid !== 1'b0 || bvalid !== 1'b0 || regs_o !== 256'h0) begin fail_count++; $display("[TB] FAIL rm_post: got w=%b rv=%b bv=%b regs=%h expected 1/0/0/0", wready, rvalid, bvalid, regs_o); end
        awaddr = 32'h0; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        repeat (3) tick();
        assert_count++; if (bvalid !== 1'b0 || regs_o !== 256'h0) begin fail_count++; $display("[TB] FAIL rm_no_commit: got bv=%b regs=%h expected 0/0", bvalid, regs_o); end
    endtask

    initial begin
        rstn = 1'b0;
        awaddr = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0;
        araddr = '0; arvalid = 1'b0;
        rready = 1'b0;
        test_reset();
        test_same_cycle_write();
        test_w_first();
        test_decerr();
        test_b_stall();
        test_read_old_value();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_axi_lite_slave_regs
